riscv_ahb_sram_slave: RTL and testbench
=======================================

# riscv_ahb_sram_slave

AHB-Lite slave that puts a single-port word-organised SRAM on the CPU's external AHB bus, which the caches' arbiter drives. It accepts pipelined address/data-phase transfers, applies per-byte write masking, inserts a configurable number of wait states and forwards write data to a back-to-back read of the same word. When enabled, it returns the two-cycle AHB ERROR response for out-of-range or oversize accesses.

## Interface
- W_ADDR, 32: address width.
- W_DATA, 32: data width; fixed at 32.
- DEPTH, 1024: memory depth in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH*4.
- WAIT_STATES, 0: data-phase wait cycles per OKAY transfer, 0..7.
- PRELOAD, "": $readmemh image; empty means contents are undefined.

Ports:
- cpu_clk  in  1  single clock; all state on rising edge.
- cpu_reset  in  1  asynchronous, active-high reset.
- s_ahb_hsel  in  1  slave select.
- s_ahb_haddr  in  W_ADDR  byte address.
- s_ahb_htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- s_ahb_hsize  in  3  0=byte, 1=half, 2=word.
- s_ahb_hwrite  in  1  1=write.
- s_ahb_hwdata  in  W_DATA  write data, valid in the data phase.
- s_ahb_hwstrb  in  4  byte strobes, valid in the data phase; ANDed with the size-derived lane mask.
- s_ahb_hready  in  1  bus-wide HREADY.
- s_ahb_hreadyout  out  1  slave ready.
- s_ahb_hresp  out  1  0=OKAY, 1=ERROR.
- s_ahb_hrdata  out  W_DATA  read data.

## Operation
- Address phase is accepted on an edge when hsel & htrans[1] & hready are all high. At that edge the block latches addr, size, write and lane mask.
- Lane mask is derived from size and the low two address bits:
  - byte: 1<<addr[1:0].
  - half: 4'b0011<<(addr[1]*2).
  - word: 4'b1111.
  - A misaligned half or word uses the aligned-down lanes.
- Word index = (haddr-BASE_ADDR)>>2.
- A read issues the RAM read at the accepting edge. The registered word is presented on hrdata when hreadyout rises.
- A write commits mask & hwstrb lanes of hwdata at the edge ending its data phase (hreadyout=1 and no error).
- Forwarding: if a read is accepted on the same edge that commits a write to the same word, the committed lanes are merged into the read data. This requires one write-data register.
- IDLE/BUSY, or hsel low with hready high: zero-wait OKAY with no side effects.
- FSM states:
  - IDLE: hreadyout=1.
  - WAIT: count down WAIT_STATES with hreadyout=0.
  - ERR1: hresp=1, hreadyout=0.
  - ERR2: hresp=1, hreadyout=1.
- FSM transitions:
  - IDLE→WAIT on an accepted transfer when WAIT_STATES>0.
  - WAIT→IDLE when the count reaches 0; that cycle has hreadyout=1.
  - IDLE→ERR1 on an accepted erroring transfer. No wait states apply.
  - ERR1→ERR2→IDLE.
- A transfer accepted during the final ready cycle (data-phase end) chains directly into its own WAIT or ERR1.
- hrdata holds its last value outside read data phases.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, pending write cleared.
- Read latency is WAIT_STATES+1 edges from address acceptance to hrdata valid with hreadyout=1.
- Write commit happens WAIT_STATES+1 edges after address acceptance.
- Back-to-back NONSEQ transfers at WAIT_STATES=0 sustain one transfer per cycle.
- hreadyout and hresp are registered outputs with no combinational path from inputs.
- Reset mid-transfer: the pending write is discarded (not committed), the count is cleared, and outputs take their reset values asynchronously.
- Wrap-around: the word index is taken modulo DEPTH when range checking is compiled out.

## Configuration
- Macro: RISCV_AHB_SRAM_ERR_EN.
- Defined:
  - Accesses with haddr outside [BASE_ADDR, BASE_ADDR+DEPTH*4) or hsize>2 take the ERR1/ERR2 sequence.
  - No RAM write occurs and hrdata is unchanged.
- Undefined:
  - hresp is tied to 0 and the ERR states are absent.
  - The address is taken modulo DEPTH words and hsize>2 is treated as a word.

## Test plan
- Reset: assert cpu_reset for 3 cycles → hreadyout=1, hresp=0, hrdata=0 throughout.
- WAIT_STATES=0, forwarding: word write 0xDEADBEEF to 0x10, immediately followed by a NONSEQ read of 0x10 → hrdata=0xDEADBEEF in the next cycle with hreadyout=1.
- Byte write lane masking: hsize=0 to 0x11 with hwdata=0x0000AA00, hwstrb=4'hF, over 0xDEADBEEF → a later read of 0x10 returns 0xDEADAAEF.
- WAIT_STATES=2 read of 0x10: hreadyout=0 for 2 cycles, then 1 with hrdata=0xDEADAAEF. Total latency is 3 edges.
- RISCV_AHB_SRAM_ERR_EN defined, DEPTH=1024, write to 0x1000:
  - hresp=1/hreadyout=0, then hresp=1/hreadyout=1, then OKAY; word 0 unchanged.
  - Without the macro, the same write lands in word 0.
- WAIT_STATES=3: assert cpu_reset during the second wait cycle of a write of 0x12345678 to 0x20 → outputs take reset values and a subsequent read of 0x20 returns the prior contents.

Source files
------------

// File: rtl/riscv_ahb_sram_slave_if.sv
// AHB-Lite bus bundle between an AHB master/interconnect and riscv_ahb_sram_slave.
interface riscv_ahb_sram_slave_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              hsel;
    logic [W_ADDR-1:0] haddr;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic              hwrite;
    logic [W_DATA-1:0] hwdata;
    logic [3:0]        hwstrb;
    logic              hready;
    logic              hreadyout;
    logic              hresp;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hsize, hwrite, hwdata, hwstrb, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hsize, hwrite, hwdata, hwstrb, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/riscv_ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte-masked writes, wait states, write-to-read forwarding.
// Define RISCV_AHB_SRAM_ERR_EN to answer out-of-range/oversize accesses with ERROR.
module riscv_ahb_sram_slave #(
    parameter int                W_ADDR      = 32,
    parameter int                W_DATA      = 32,
    parameter int                DEPTH       = 1024,
    parameter logic [W_ADDR-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0,
    parameter string             PRELOAD     = ""
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_reset,
    riscv_ahb_sram_slave_if.slave s_ahb
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

`ifdef RISCV_AHB_SRAM_ERR_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_e;
`endif

    logic [W_DATA-1:0] mem [DEPTH];

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic              hreadyout_q;
    logic [W_DATA-1:0] hrdata_q;
    logic              active_q;
    logic              write_q;
    logic [AW-1:0]     idx_q;
    logic [3:0]        mask_q;

    logic              accept;
    logic              err;
    logic [W_ADDR-1:0] offset;
    logic [AW-1:0]     idx;
    logic [3:0]        lanes;
    logic              commit;
    logic [3:0]        wr_lanes;
    logic [W_DATA-1:0] wr_bits;
    logic [W_DATA-1:0] rd_merged;
    logic              unused_bits;

    assign accept = s_ahb.hsel & s_ahb.htrans[1] & s_ahb.hready;
    assign offset = s_ahb.haddr - BASE_ADDR;
    assign idx    = offset[AW+1:2];

`ifdef RISCV_AHB_SRAM_ERR_EN
    localparam logic [W_ADDR-1:0] SPAN = W_ADDR'(DEPTH) << 2;
    logic hresp_q;
    assign err          = (offset >= SPAN) || (s_ahb.hsize > 3'd2);
    assign s_ahb.hresp  = hresp_q;
    assign unused_bits  = s_ahb.htrans[0];
`else
    // Without range checking the upper offset bits simply alias onto the array.
    assign err          = 1'b0;
    assign s_ahb.hresp  = 1'b0;
    assign unused_bits  = ^{s_ahb.htrans[0], offset[W_ADDR-1:AW+2]};
`endif

    // NOTE: every branch assigns lanes (default included), so no latch is inferred.
    always_comb begin
        case (s_ahb.hsize)
            3'd0:    lanes = 4'b0001 << offset[1:0];
            3'd1:    lanes = offset[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    // A write's data phase ends on the first edge where we are ready again.
    assign commit   = active_q & write_q & hreadyout_q;
    assign wr_lanes = mask_q & s_ahb.hwstrb;
    assign wr_bits  = {{8{wr_lanes[3]}}, {8{wr_lanes[2]}}, {8{wr_lanes[1]}}, {8{wr_lanes[0]}}};
    assign rd_merged = (commit && (idx_q == idx))
                     ? ((mem[idx] & ~wr_bits) | (s_ahb.hwdata & wr_bits))
                     : mem[idx];

    // NOTE: the SRAM array has no reset; only control state is cleared by cpu_reset.
    always_ff @(posedge cpu_clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_lanes[b]) mem[idx_q][8*b +: 8] <= s_ahb.hwdata[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            hreadyout_q <= 1'b1;
            hrdata_q    <= '0;
            active_q    <= 1'b0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            mask_q      <= 4'b0000;
`ifdef RISCV_AHB_SRAM_ERR_EN
            hresp_q     <= 1'b0;
`endif
        end else if (hreadyout_q) begin
            // Ready cycle: any current data phase ends here and a new one may start.
            active_q <= accept & ~err;
            state_q  <= ST_IDLE;
`ifdef RISCV_AHB_SRAM_ERR_EN
            hresp_q  <= 1'b0;
`endif
            if (accept) begin
                idx_q   <= idx;
                mask_q  <= lanes;
                write_q <= s_ahb.hwrite;
            end
            if (accept && !err && !s_ahb.hwrite) hrdata_q <= rd_merged;
`ifdef RISCV_AHB_SRAM_ERR_EN
            if (accept && err) begin
                state_q     <= ST_ERR1;
                hreadyout_q <= 1'b0;
                hresp_q     <= 1'b1;
            end else
`endif
            if (accept && WAIT_STATES != 0) begin
                state_q     <= ST_WAIT;
                cnt_q       <= WS_LAST;
                hreadyout_q <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
`ifdef RISCV_AHB_SRAM_ERR_EN
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ahb.hreadyout = hreadyout_q;
    assign s_ahb.hrdata    = hrdata_q;

endmodule

// File: tb/tb_riscv_ahb_sram_slave.sv
// Three SRAM slaves (0/2/3 wait states) on one AHB bus, checked against a sequential memory model.
module tb_riscv_ahb_sram_slave;

    typedef enum int {K_XFER, K_IDLE, K_NOSEL} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          slv;
        logic        err;
        logic [31:0] exp_rd;
        logic [31:0] exp_hold;
    } xfer_t;

    logic        clk;
    logic        rst;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic [2:0]  m_hsize;
    logic        m_hwrite;
    logic [31:0] m_hwdata;
    logic [3:0]  m_hwstrb;
    logic        bus_hready;
    logic        bus_hresp;
    logic [31:0] bus_hrdata;
    logic        s_rdy   [3];
    logic        s_resp  [3];
    logic [31:0] s_rdata [3];
    int          sel_dp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl [3][1024];
    logic [31:0] last_rd [3];
    xfer_t       pend [$];

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_s
        riscv_ahb_sram_slave_if #(.W_ADDR(32), .W_DATA(32)) ifc ();
        assign ifc.hsel   = (m_haddr[31:16] == 16'(k));
        assign ifc.haddr  = m_haddr;
        assign ifc.htrans = m_htrans;
        assign ifc.hsize  = m_hsize;
        assign ifc.hwrite = m_hwrite;
        assign ifc.hwdata = m_hwdata;
        assign ifc.hwstrb = m_hwstrb;
        assign ifc.hready = bus_hready;
        assign s_rdy[k]   = ifc.hreadyout;
        assign s_resp[k]  = ifc.hresp;
        assign s_rdata[k] = ifc.hrdata;

        riscv_ahb_sram_slave #(
            .W_ADDR(32), .W_DATA(32), .DEPTH(1024),
            .BASE_ADDR(32'(k) << 16),
            .WAIT_STATES((k == 0) ? 0 : ((k == 1) ? 2 : 3)),
            .PRELOAD("")
        ) u_dut (
            .cpu_clk(clk),
            .cpu_reset(rst),
            .s_ahb(ifc.slave)
        );
    end

    // Bus data-phase mux: which slave owns the current data phase (3 = none).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_dp <= 3;
        else if (bus_hready)
            sel_dp <= (m_htrans[1] && m_haddr[31:16] < 16'd3) ? int'(m_haddr[31:16]) : 3;
    end

    always_comb begin
        bus_hready = 1'b1;
        bus_hresp  = 1'b0;
        bus_hrdata = '0;
        if (sel_dp < 3) begin
            bus_hready = s_rdy[sel_dp];
            bus_hresp  = s_resp[sel_dp];
            bus_hrdata = s_rdata[sel_dp];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: memory is sequentially consistent in issue order; errors leave it untouched.
    function automatic xfer_t model(input xfer_t t);
        logic [31:0] off;
        logic [3:0]  ln;
        int          idx;
        t.slv = int'(t.addr[31:16]);
        off   = {16'h0, t.addr[15:0]};
        idx   = int'(off[31:2]) % 1024;
        if (t.size == 3'd0)      ln = 4'b0001 << off[1:0];
        else if (t.size == 3'd1) ln = off[1] ? 4'b1100 : 4'b0011;
        else                     ln = 4'b1111;
`ifdef RISCV_AHB_SRAM_ERR_EN
        t.err = (off >= 32'h1000) || (t.size > 3'd2);
`else
        t.err = 1'b0;
`endif
        t.exp_hold = last_rd[t.slv];
        t.exp_rd   = 32'h0;
        if (!t.err) begin
            if (t.wr) begin
                for (int b = 0; b < 4; b++)
                    if (ln[b] && t.strb[b]) mdl[t.slv][idx][8*b +: 8] = t.wdata[8*b +: 8];
            end else begin
                t.exp_rd        = mdl[t.slv][idx];
                last_rd[t.slv]  = t.exp_rd;
            end
        end
        return t;
    endfunction

    task automatic push_x(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] strb);
        xfer_t t;
        t.kind = K_XFER; t.addr = addr; t.size = size; t.wr = wr;
        t.wdata = wdata; t.strb = strb;
        pend.push_back(model(t));
    endtask

    task automatic push_gap(input kind_e k);
        xfer_t t;
        t.kind = k; t.size = 3'd2; t.wr = 1'b0; t.wdata = '0; t.strb = '0;
        t.slv = 0; t.err = 1'b0; t.exp_rd = '0; t.exp_hold = '0;
        t.addr = (k == K_NOSEL) ? (32'h0003_0000 | 32'($urandom_range(0, 255)))
                                : 32'($urandom_range(0, 63));
        pend.push_back(t);
    endtask

    task automatic drive_ap(input xfer_t t, input bit v);
        if (!v) begin
            m_htrans = 2'b00;
        end else begin
            m_haddr  = t.addr;
            m_hsize  = t.size;
            m_hwrite = t.wr;
            m_htrans = (t.kind == K_IDLE) ? 2'($urandom_range(0, 1)) : 2'b10;
        end
    endtask

    // Pipelined master: address phase of the next transfer overlaps the current data phase.
    task automatic run_pending();
        xfer_t ap, dp;
        bit    ap_v, dp_v, rdy;
        int    stalls, guard;
        dp_v = 1'b0; stalls = 0; guard = 0;
        @(negedge clk);
        ap_v = (pend.size() > 0);
        if (ap_v) ap = pend.pop_front();
        drive_ap(ap, ap_v);
        while ((ap_v || dp_v) && guard < 20000) begin
            guard++;
            rdy = bus_hready;
            if (dp_v) begin
                check("hresp", 32'(bus_hresp), 32'(dp.err));
                if (!rdy) begin
                    stalls++;
                    if (stalls > 8) begin
                        check("stall_bound", stalls, dp.err ? 1 : ws_of(dp.slv));
                        return;
                    end
                end else begin
                    check("stalls", stalls, dp.err ? 1 : ws_of(dp.slv));
                    if (!dp.wr && !dp.err) check("rdata", bus_hrdata, dp.exp_rd);
                    else                   check("rdata_hold", bus_hrdata, dp.exp_hold);
                end
            end
            @(negedge clk);
            if (rdy) begin
                dp_v     = ap_v && (ap.kind == K_XFER);
                dp       = ap;
                stalls   = 0;
                m_hwdata = (dp_v && dp.wr) ? dp.wdata : $urandom;
                m_hwstrb = (dp_v && dp.wr) ? dp.strb  : 4'($urandom);
                ap_v     = (pend.size() > 0);
                if (ap_v) ap = pend.pop_front();
                drive_ap(ap, ap_v);
            end
        end
        if (guard >= 20000) check("run_bound", 32'(guard), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          s;
        rst = 1'b1;
        m_haddr = '0; m_htrans = 2'b00; m_hsize = 3'd2; m_hwrite = 1'b0;
        m_hwdata = '0; m_hwstrb = 4'h0;
        last_rd = '{32'h0, 32'h0, 32'h0};

        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check("rst_hreadyout", 32'(s_rdy[k]), 32'd1);
                check("rst_hresp",     32'(s_resp[k]), 32'd0);
                check("rst_hrdata",    s_rdata[k],     32'h0);
            end
        end
        rst = 1'b0;

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++)
                push_x((32'(k) << 16) | 32'(i * 4), 3'd2, 1'b1, $urandom, 4'hF);
        run_pending();

        // Forwarding, byte masking, wait-state read and out-of-range write.
        push_x(32'h0000_0010, 3'd2, 1'b1, 32'hDEAD_BEEF, 4'hF);
        push_x(32'h0000_0010, 3'd2, 1'b0, 32'h0, 4'h0);
        push_x(32'h0000_0011, 3'd0, 1'b1, 32'h0000_AA00, 4'hF);
        push_x(32'h0000_0010, 3'd2, 1'b0, 32'h0, 4'h0);
        push_x(32'h0001_0010, 3'd2, 1'b1, 32'hDEAD_AAEF, 4'hF);
        push_gap(K_IDLE);
        push_x(32'h0001_0010, 3'd2, 1'b0, 32'h0, 4'h0);
        push_x(32'h0000_1000, 3'd2, 1'b1, 32'hCAFE_F00D, 4'hF);
        push_x(32'h0000_0000, 3'd2, 1'b0, 32'h0, 4'h0);
        run_pending();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                push_gap(($urandom_range(0, 1) == 0) ? K_IDLE : K_NOSEL);
            end else begin
                s = $urandom_range(0, 2);
                a = (32'(s) << 16) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = a + 32'h1000 * 32'($urandom_range(1, 3));
                push_x(a, ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)), $urandom, 4'($urandom));
            end
        end
        run_pending();

        // Reset in the second wait cycle of a write: the write must be dropped.
        @(negedge clk);
        m_haddr = 32'h0002_0020; m_hsize = 3'd2; m_hwrite = 1'b1; m_htrans = 2'b10;
        @(negedge clk);
        m_htrans = 2'b00; m_hwdata = 32'h1234_5678; m_hwstrb = 4'hF;
        check("mr_wait1", 32'(s_rdy[2]), 32'd0);
        @(negedge clk);
        check("mr_wait2", 32'(s_rdy[2]), 32'd0);
        rst = 1'b1;
        #1;
        check("mr_hreadyout", 32'(s_rdy[2]), 32'd1);
        check("mr_hresp",     32'(s_resp[2]), 32'd0);
        check("mr_hrdata",    s_rdata[2],     32'h0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '{32'h0, 32'h0, 32'h0};
        push_x(32'h0002_0020, 3'd2, 1'b0, 32'h0, 4'h0);
        run_pending();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
